// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the eth_tx round-robin arbiter.
package eth_tx_arb_pkg;

  // Widths for the default 16-bit datapath with 8-byte PCS blocks.
  localparam int unsigned LEN_W          = $clog2(16 / 8 + 1);
  localparam int unsigned APP_LAST_LEN_W = $clog2(8 + 16 / 8 + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StData
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// Requester-side and eth_tx-side signals of the arbiter, flattened per requester.
interface eth_tx_arb_if #(
  parameter int unsigned REQ_N          = 2,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned LEN_W          = 2,
  parameter int unsigned PKT_LEN_W      = 16,
  parameter int unsigned UDP_CS_W       = 16,
  parameter int unsigned APP_LAST_LEN_W = 4
);

  logic [REQ_N-1:0]                req_early_v_i;
  logic [REQ_N-1:0]                req_ready_v_o;
  logic [REQ_N-1:0]                req_cancel_i;
  logic [REQ_N*DATA_W-1:0]         req_data_i;
  logic [REQ_N*LEN_W-1:0]          req_len_i;
  logic [REQ_N*PKT_LEN_W-1:0]      req_pkt_len_i;
  logic [REQ_N*UDP_CS_W-1:0]       req_cs_i;
  logic [REQ_N-1:0]                req_last_i;
  logic [REQ_N-1:0]                req_last_block_next_i;
  logic [REQ_N*APP_LAST_LEN_W-1:0] req_last_block_next_len_i;

  logic                      tx_early_v_o;
  logic                      tx_ready_v_i;
  logic                      tx_cancel_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic [LEN_W-1:0]          tx_len_o;
  logic [PKT_LEN_W-1:0]      tx_pkt_len_o;
  logic [UDP_CS_W-1:0]       tx_cs_o;
  logic                      tx_last_o;
  logic                      tx_last_block_next_o;
  logic [APP_LAST_LEN_W-1:0] tx_last_block_next_len_o;

  // Environment side: requesters plus the eth_tx ready return.
  modport master (
    output req_early_v_i, req_cancel_i, req_data_i, req_len_i, req_pkt_len_i, req_cs_i,
           req_last_i, req_last_block_next_i, req_last_block_next_len_i, tx_ready_v_i,
    input  req_ready_v_o, tx_early_v_o, tx_cancel_o, tx_data_o, tx_len_o, tx_pkt_len_o,
           tx_cs_o, tx_last_o, tx_last_block_next_o, tx_last_block_next_len_o
  );

  // Arbiter side.
  modport slave (
    input  req_early_v_i, req_cancel_i, req_data_i, req_len_i, req_pkt_len_i, req_cs_i,
           req_last_i, req_last_block_next_i, req_last_block_next_len_i, tx_ready_v_i,
    output req_ready_v_o, tx_early_v_o, tx_cancel_o, tx_data_o, tx_len_o, tx_pkt_len_o,
           tx_cs_o, tx_last_o, tx_last_block_next_o, tx_last_block_next_len_o
  );

endinterface

// File: rtl/eth_tx_arb_rr.sv
// Rotating-priority one-hot picker with a pointer that moves past the last owner on i_adv.
module eth_tx_arb_rr
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned REQ_N = 2,
  parameter int unsigned PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [REQ_N-1:0] i_req,
  input  logic             i_adv,
  input  logic [PTR_W-1:0] i_adv_idx,
  output logic [REQ_N-1:0] o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = r_ptr;
    for (int unsigned off = 0; off < REQ_N; off++) begin
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
      w_idx = PTR_W'(rr_next(32'(w_idx), REQ_N));
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= PTR_W'(rr_next(32'(i_adv_idx), REQ_N));
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter sharing one eth_tx between REQ_N requesters.
// Optional ETH_TX_ARB_WATCHDOG_EN aborts a grant held for WDOG_CYC cycles.
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned REQ_N          = 2,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W      = 16,
  parameter int unsigned UDP_CS_W       = 16,
  parameter int unsigned BLOCK_N        = 8,
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1)
`ifdef ETH_TX_ARB_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYC       = 2048
`endif
) (
  input  logic             clk,
  input  logic             nreset,
  eth_tx_arb_if.slave      bus,
  output logic [REQ_N-1:0] grant_o,
  output logic             wdog_o
);

  localparam int unsigned PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  arb_state_e       r_state;
  logic [REQ_N-1:0] r_grant;
  logic [PTR_W-1:0] r_gidx;

  logic [REQ_N-1:0] w_req_ok;
  logic [REQ_N-1:0] w_pick;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_early, w_cancel, w_last;
  logic             w_end, w_to_data, w_abort, w_adv;

  logic [REQ_N-1:0]          w_ready;
  logic                      w_tx_early, w_tx_cancel, w_tx_last, w_tx_lbn;
  logic [DATA_W-1:0]         w_tx_data;
  logic [LEN_W-1:0]          w_tx_len;
  logic [PKT_LEN_W-1:0]      w_tx_pkt_len;
  logic [UDP_CS_W-1:0]       w_tx_cs;
  logic [APP_LAST_LEN_W-1:0] w_tx_lbn_len;

  assign w_req_ok = bus.req_early_v_i & ~bus.req_cancel_i;

  eth_tx_arb_rr #(
    .REQ_N(REQ_N),
    .PTR_W(PTR_W)
  ) u_rr (
    .clk       (clk),
    .nreset    (nreset),
    .i_req     (w_req_ok),
    .i_adv     (w_adv),
    .i_adv_idx (r_gidx),
    .o_gnt     (w_pick),
    .o_gnt_idx (w_pick_idx),
    .o_any     (w_pick_any)
  );

  assign w_early  = bus.req_early_v_i[r_gidx];
  assign w_cancel = bus.req_cancel_i[r_gidx];
  assign w_last   = bus.req_last_i[r_gidx];

  always_comb begin
    w_end     = 1'b0;
    w_to_data = 1'b0;
    case (r_state)
      StWait: begin
        if (w_cancel || !w_early) begin
          w_end = 1'b1;
        end else if (bus.tx_ready_v_i) begin
          w_to_data = 1'b1;
        end
      end
      StData:  w_end = w_last || w_cancel;
      default: ;
    endcase
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

  logic [CNT_W-1:0] r_cnt;

  // A regular exit in the limit cycle wins over the abort.
  assign w_abort = (r_state != StIdle) && (r_cnt == CNT_W'(WDOG_CYC - 1)) && !w_end;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (r_state == StIdle) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  assign w_adv = w_end || w_abort;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_gidx  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_pick_any) begin
            r_state <= StWait;
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
          end
        end
        StWait, StData: begin
          if (w_adv) begin
            r_state <= StIdle;
            r_grant <= '0;
          end else if (w_to_data) begin
            r_state <= StData;
          end
        end
        default: begin
          r_state <= StIdle;
          r_grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_ready      = '0;
    w_tx_early   = 1'b0;
    w_tx_cancel  = 1'b0;
    w_tx_last    = 1'b0;
    w_tx_lbn     = 1'b0;
    w_tx_data    = '0;
    w_tx_len     = '0;
    w_tx_pkt_len = '0;
    w_tx_cs      = '0;
    w_tx_lbn_len = '0;
    if (r_state != StIdle) begin
      w_tx_pkt_len = bus.req_pkt_len_i[int'(r_gidx)*PKT_LEN_W +: PKT_LEN_W];
      w_tx_data    = bus.req_data_i[int'(r_gidx)*DATA_W +: DATA_W];
      w_tx_len     = bus.req_len_i[int'(r_gidx)*LEN_W +: LEN_W];
      w_tx_cs      = bus.req_cs_i[int'(r_gidx)*UDP_CS_W +: UDP_CS_W];
      w_tx_lbn_len = bus.req_last_block_next_len_i[int'(r_gidx)*APP_LAST_LEN_W +: APP_LAST_LEN_W];
      if (!w_abort) begin
        w_ready[r_gidx] = bus.tx_ready_v_i;
      end
    end
    if (r_state == StWait) begin
      w_tx_early = w_early;
    end
    if (r_state == StData) begin
      w_tx_last   = w_last;
      w_tx_lbn    = bus.req_last_block_next_i[r_gidx];
      w_tx_cancel = w_cancel;
    end
    if (w_abort) begin
      w_tx_cancel = 1'b1;
    end
  end

  assign bus.req_ready_v_o            = w_ready;
  assign bus.tx_early_v_o             = w_tx_early;
  assign bus.tx_cancel_o              = w_tx_cancel;
  assign bus.tx_data_o                = w_tx_data;
  assign bus.tx_len_o                 = w_tx_len;
  assign bus.tx_pkt_len_o             = w_tx_pkt_len;
  assign bus.tx_cs_o                  = w_tx_cs;
  assign bus.tx_last_o                = w_tx_last;
  assign bus.tx_last_block_next_o     = w_tx_lbn;
  assign bus.tx_last_block_next_len_o = w_tx_lbn_len;

  assign grant_o = r_grant;
  assign wdog_o  = w_abort;

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Round-robin scheduler that shares one eth_tx instance between REQ_N application requesters, e.g. independent order-entry sessions.
- Grants the TX path for a whole packet, from the early-valid handshake through the last beat or a cancel.
- Muxes the granted requester's beat fields onto the eth_tx app interface and routes app_ready_v_o back to that requester only.
- Sits between the application layer and eth_tx, in the same clock domain.

Parameters:
- REQ_N, 2, number of requesters (2..8).
- DATA_W, 16, beat width in bits.
- KEEP_W, DATA_W/8, bytes per beat.
- LEN_W, $clog2(KEEP_W+1), beat byte-count width.
- PKT_LEN_W, 16, packet length width.
- UDP_CS_W, 16, checksum width.
- BLOCK_N, 8, PCS block bytes.
- APP_LAST_LEN_W, $clog2(BLOCK_N+KEEP_W+1), last-block length width.
- WDOG_CYC, 2048, watchdog limit in cycles; used only with the watchdog macro.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- req_early_v_i  in  REQ_N  per-requester packet request; held until ready.
- req_ready_v_o  out  REQ_N  tx ready routed to the granted requester.
- req_cancel_i  in  REQ_N  per-requester cancel.
- req_data_i  in  REQ_N*DATA_W  beat data, requester k at [k*DATA_W+:DATA_W].
- req_len_i  in  REQ_N*LEN_W  beat byte count.
- req_pkt_len_i  in  REQ_N*PKT_LEN_W  packet length, valid with early_v.
- req_cs_i  in  REQ_N*UDP_CS_W  UDP checksum.
- req_last_i  in  REQ_N  last beat.
- req_last_block_next_i  in  REQ_N  next block is last.
- req_last_block_next_len_i  in  REQ_N*APP_LAST_LEN_W  length of that block.
- tx_early_v_o  out  1  to eth_tx app_early_v_i.
- tx_ready_v_i  in  1  from eth_tx app_ready_v_o.
- tx_cancel_o  out  1  to eth_tx app_cancel_i.
- tx_data_o  out  DATA_W  to eth_tx.
- tx_len_o  out  LEN_W  to eth_tx.
- tx_pkt_len_o  out  PKT_LEN_W  to eth_tx.
- tx_cs_o  out  UDP_CS_W  to eth_tx.
- tx_last_o  out  1  to eth_tx.
- tx_last_block_next_o  out  1  to eth_tx.
- tx_last_block_next_len_o  out  APP_LAST_LEN_W  to eth_tx.
- grant_o  out  REQ_N  registered one-hot current owner; 0 when idle.
- wdog_o  out  1  one-cycle watchdog-abort pulse.

Behaviour:
- Reset: state=IDLE, grant_o=0, rr pointer=0, wdog_o=0. All control outputs (tx_early_v_o, tx_cancel_o, tx_last_o, tx_last_block_next_o, req_ready_v_o) are 0 while grant_o=0.
- FSM states: IDLE, WAIT, DATA.
- IDLE:
  - If any req_early_v_i & ~req_cancel_i is set, pick the first set bit at or after the pointer, wrapping.
  - Register grant_o one-hot for the winner; go to WAIT.
  - Arbitration latency: 1 cycle.
- WAIT:
  - tx_early_v_o = req_early_v_i[g] and tx_pkt_len_o = req_pkt_len_i[g], both combinational.
  - req_ready_v_o[g] = tx_ready_v_i, combinational, zero added latency; all other bits are 0.
  - If tx_ready_v_i & req_early_v_i[g], go to DATA.
  - If req_cancel_i[g], or req_early_v_i[g] drops without ready: go to IDLE, clear grant, pointer=g+1 mod REQ_N, tx_cancel_o=0.
- DATA:
  - All beat fields (data, len, cs, last, last_block_next, last_block_next_len) combinationally muxed from g.
  - tx_early_v_o=0.
  - tx_cancel_o = req_cancel_i[g].
  - If req_last_i[g] or req_cancel_i[g], go to IDLE; grant clears next cycle; pointer=g+1 mod REQ_N.
- Simultaneous last and cancel: cancel is forwarded; state goes to IDLE.
- Requests from non-granted requesters are ignored and never forwarded; they are held pending until granted.
- The cycle after a packet ends is always IDLE, so there is one arbitration gap per packet.
- Data fields while grant_o=0 are don't-care; drive 0.
- Reset asserted mid-packet: immediate return to reset state; no cancel is emitted.
- No starvation: every pending requester is granted within REQ_N packets.

Optional Feature:
- Macro: ETH_TX_ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments in WAIT and DATA.
  - When it reaches WDOG_CYC-1 without an exit: tx_cancel_o=1 and wdog_o=1 for one cycle, state goes to IDLE, pointer advances.
  - req_ready_v_o[g]=0 during the abort cycle.
- Undefined: no counter; wdog_o tied 0.

Decomposition:
- Package eth_tx_arb_pkg holds:
  - the state enum (IDLE/WAIT/DATA);
  - the width localparams (LEN_W, APP_LAST_LEN_W);
  - a function returning the next rr index.
- Sub-module eth_tx_arb_rr: rotating-priority one-hot picker plus pointer register with an advance strobe.
- The top module holds the FSM, the muxes and the watchdog.

Test Plan:
- Single packet: REQ_N=2, req0 early with pkt_len=10, tx_ready after 3 cycles → tx_early_v_o from cycle 1, req_ready_v_o=2'b01 only, 5 data beats forwarded bit-exact, grant_o returns to 0 the cycle after last.
- Contention: req0 and req1 early in the same cycle, pointer=0 → req0 served first; req1 granted in the IDLE cycle right after req0's last; pointer ends at 0.
- Fairness: req0 re-requests continuously and req1 is pending → grants alternate 01,10,01,10 over 4 packets.
- Cancel in DATA: req1 asserts cancel on beat 2 of 8 → tx_cancel_o=1 that cycle, FSM goes to IDLE, no further beats forwarded.
- Drop in WAIT: req0 drops early before ready → grant clears, tx_early_v_o=0, no ready pulse to req0.
- Watchdog (macro on, WDOG_CYC=16): granted requester never asserts last → tx_cancel_o and wdog_o pulse at cycle 15 after the grant, grant clears.
